// File: rtl/mem_cycle_sequencer.sv
// Memory-cycle sequencer: latches an address and steps one MCT of NT timepulses,
// driving registered one-hot selects, read/write pulses and the sense strobe.
module mem_cycle_sequencer #(
  parameter int XW       = 3,
  parameter int YW       = 2,
  parameter int NT       = 12,
  parameter int RD_S     = 2,
  parameter int RD_E     = 4,
  parameter int STB_TP   = 4,
  parameter int WR_S     = 7,
  parameter int WR_E     = 10,
  parameter int ERAS_TOP = 8
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic             start,
  input  logic [XW+YW-1:0] addr,
  input  logic             sby,
  input  logic             wrinh,
  output logic             busy,
  output logic [3:0]       tp,
  output logic [2**XW-1:0] xsel,
  output logic [2**YW-1:0] ysel,
  output logic             eras,
  output logic             rex,
  output logic             stb,
  output logic             wex,
  output logic             done
);

  localparam int AW = XW + YW;
  localparam logic [3:0] TN  = 4'(NT);
  localparam logic [3:0] TRS = 4'(RD_S);
  localparam logic [3:0] TRE = 4'(RD_E);
  localparam logic [3:0] TST = 4'(STB_TP);
  localparam logic [3:0] TWS = 4'(WR_S);
  localparam logic [3:0] TWE = 4'(WR_E);

  if (!(RD_S <= RD_E && RD_E < WR_S && WR_S <= WR_E &&
        WR_E < NT && STB_TP >= 1 && STB_TP < NT &&
        NT >= 4 && NT <= 15)) begin : g_bad_params
    $error("mem_cycle_sequencer: illegal timing parameters");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [3:0]       tp_n;
  logic [AW-1:0]    a_q, a_n;
  logic             wi_q, wi_n, eras_n;
  logic             acc, run_n, act_n;
  logic [2**XW-1:0] xsel_n;
  logic [2**YW-1:0] ysel_n;
  logic             rex_n, stb_n, wex_n, done_n;

  always_comb begin
    acc     = start && !sby && (state == IDLE || tp == TN);
    state_n = state;
    tp_n    = tp;
    a_n     = a_q;
    wi_n    = wi_q;
    eras_n  = eras;
    if (acc) begin
      state_n = RUN;
      tp_n    = 4'd1;
      a_n     = addr;
      wi_n    = wrinh;
      eras_n  = 32'(addr) < ERAS_TOP;
    end else if (state == RUN) begin
      if (tp == TN) begin
        state_n = IDLE;
        tp_n    = 4'd0;
      end else begin
        tp_n = tp + 4'd1;
      end
    end
    // outputs are decoded from the timepulse they will sit alongside
    run_n  = state_n == RUN;
    act_n  = run_n && tp_n != TN;
    xsel_n = '0;
    ysel_n = '0;
    if (act_n) begin
      xsel_n[a_n[XW-1:0]]  = 1'b1;
      ysel_n[a_n[AW-1:XW]] = 1'b1;
    end
    rex_n  = run_n && tp_n >= TRS && tp_n <= TRE;
    stb_n  = run_n && tp_n == TST;
    wex_n  = run_n && tp_n >= TWS && tp_n <= TWE &&
             eras_n && !wi_n;
    done_n = run_n && tp_n == TN;
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state <= IDLE;
      tp    <= '0;
      a_q   <= '0;
      wi_q  <= 1'b0;
      eras  <= 1'b0;
      busy  <= 1'b0;
      xsel  <= '0;
      ysel  <= '0;
      rex   <= 1'b0;
      stb   <= 1'b0;
      wex   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      tp    <= tp_n;
      a_q   <= a_n;
      wi_q  <= wi_n;
      eras  <= eras_n;
      busy  <= run_n;
      xsel  <= xsel_n;
      ysel  <= ysel_n;
      rex   <= rex_n;
      stb   <= stb_n;
      wex   <= wex_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Bench for mem_cycle_sequencer: table of per-clock vectors on two instances
// (all-erasable and ERAS_TOP=8) plus a back-to-back done-spacing sequence.
module tb_mem_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sby = 1'b0;
  logic       wrinh = 1'b0;
  logic [4:0] addr = '0;

  logic       e_busy, e_eras, e_rex, e_stb, e_wex, e_done;
  logic [3:0] e_tp, e_ysel;
  logic [7:0] e_xsel;
  logic       f_busy, f_eras, f_rex, f_stb, f_wex, f_done;
  logic [3:0] f_tp, f_ysel;
  logic [7:0] f_xsel;

  always #5 clk = ~clk;

  mem_cycle_sequencer #(.ERAS_TOP(32)) u_e (
    .CLOCK(clk), .rst(rst), .start(start), .addr(addr),
    .sby(sby), .wrinh(wrinh), .busy(e_busy), .tp(e_tp),
    .xsel(e_xsel), .ysel(e_ysel), .eras(e_eras), .rex(e_rex),
    .stb(e_stb), .wex(e_wex), .done(e_done)
  );

  mem_cycle_sequencer u_f (
    .CLOCK(clk), .rst(rst), .start(start), .addr(addr),
    .sby(sby), .wrinh(wrinh), .busy(f_busy), .tp(f_tp),
    .xsel(f_xsel), .ysel(f_ysel), .eras(f_eras), .rex(f_rex),
    .stb(f_stb), .wex(f_wex), .done(f_done)
  );

  typedef struct {
    bit       rst, start, sby, wrinh;
    bit [4:0] addr;
    bit [3:0] tp;
    bit       busy;
    bit [7:0] xsel;
    bit [3:0] ysel;
    bit       rex, stb, done, wex_e, wex_f;
    bit       ce, er_e, er_f;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   row = 0;

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row=%0d got=%0h exp=%0h", n, row, got, exp);
    end
  endtask

  function automatic void add_idle(bit st, bit sb, bit r);
    vec_t v = '{default: 0};
    v.rst = r;
    v.start = st;
    v.sby = sb;
    v.ce = r;
    tbl.push_back(v);
  endfunction

  function automatic void add_cycle(bit [4:0] a, bit hold, int sby_from,
                                    int ign_t, bit wi, int last_t);
    for (int t = 1; t <= last_t; t++) begin
      vec_t v = '{default: 0};
      v.start = (t == 1) || hold || (t == ign_t);
      v.sby   = t >= sby_from;
      v.wrinh = (t == 1) ? wi : !wi;
      v.addr  = (t == 1) ? a : ~a;
      v.tp    = 4'(t);
      v.busy  = 1'b1;
      if (t < 12) begin
        v.xsel = 8'd1 << a[2:0];
        v.ysel = 4'd1 << a[4:3];
      end
      v.rex   = t >= 2 && t <= 4;
      v.stb   = t == 4;
      v.done  = t == 12;
      v.wex_e = t >= 7 && t <= 10 && !wi;
      v.wex_f = v.wex_e && (a < 8);
      v.ce    = 1'b1;
      v.er_e  = 1'b1;
      v.er_f  = a < 8;
      tbl.push_back(v);
    end
  endfunction

  initial begin
    int prev;
    int ndone;
    bit drained;

    // reset held with start high
    add_idle(1, 0, 1);
    add_idle(1, 0, 1);
    add_idle(0, 0, 0);
    // erasable cycle, addr 19
    add_cycle(5'd19, 0, 99, 0, 0, 12);
    add_idle(0, 0, 0);
    // fixed cycle on ERAS_TOP=8 instance
    add_cycle(5'd20, 0, 99, 0, 0, 12);
    add_idle(0, 0, 0);
    // back-to-back with start held
    add_cycle(5'd3, 1, 99, 0, 0, 12);
    add_cycle(5'd10, 1, 99, 0, 0, 12);
    add_cycle(5'd29, 1, 99, 0, 0, 12);
    add_idle(0, 0, 0);
    // start at tp=5 ignored
    add_cycle(5'd19, 0, 99, 6, 0, 12);
    add_idle(0, 0, 0);
    // standby blocks acceptance
    add_idle(1, 1, 0);
    add_idle(1, 1, 0);
    // standby raised at tp=3 mid-cycle
    add_cycle(5'd5, 1, 4, 0, 0, 12);
    add_idle(1, 1, 0);
    add_idle(0, 0, 0);
    // abort at tp=8
    add_cycle(5'd7, 0, 99, 0, 0, 8);
    add_idle(0, 0, 1);
    add_idle(0, 0, 0);
    // write-back inhibited
    add_cycle(5'd6, 0, 99, 0, 1, 12);
    add_idle(0, 0, 0);

    foreach (tbl[i]) begin
      row   = i;
      rst   = tbl[i].rst;
      start = tbl[i].start;
      sby   = tbl[i].sby;
      wrinh = tbl[i].wrinh;
      addr  = tbl[i].addr;
      @(posedge clk);
      #1;
      chk("e_tp", 32'(e_tp), 32'(tbl[i].tp));
      chk("e_busy", 32'(e_busy), 32'(tbl[i].busy));
      chk("e_xsel", 32'(e_xsel), 32'(tbl[i].xsel));
      chk("e_ysel", 32'(e_ysel), 32'(tbl[i].ysel));
      chk("e_rex", 32'(e_rex), 32'(tbl[i].rex));
      chk("e_stb", 32'(e_stb), 32'(tbl[i].stb));
      chk("e_wex", 32'(e_wex), 32'(tbl[i].wex_e));
      chk("e_done", 32'(e_done), 32'(tbl[i].done));
      chk("f_tp", 32'(f_tp), 32'(tbl[i].tp));
      chk("f_xsel", 32'(f_xsel), 32'(tbl[i].xsel));
      chk("f_ysel", 32'(f_ysel), 32'(tbl[i].ysel));
      chk("f_rex", 32'(f_rex), 32'(tbl[i].rex));
      chk("f_stb", 32'(f_stb), 32'(tbl[i].stb));
      chk("f_wex", 32'(f_wex), 32'(tbl[i].wex_f));
      chk("f_done", 32'(f_done), 32'(tbl[i].done));
      if (tbl[i].ce) begin
        chk("e_eras", 32'(e_eras), 32'(tbl[i].er_e));
        chk("f_eras", 32'(f_eras), 32'(tbl[i].er_f));
      end
    end

    // done spacing over a held start
    row   = tbl.size();
    rst   = 1'b0;
    sby   = 1'b0;
    wrinh = 1'b0;
    start = 1'b1;
    addr  = 5'd9;
    prev  = -1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      chk("b2b_busy", 32'(e_busy), 32'd1);
      if (e_done) begin
        if (prev >= 0) chk("done_gap", 32'(c - prev), 32'd12);
        prev = c;
        ndone++;
      end
    end
    chk("done_count", 32'(ndone), 32'd3);
    start = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 20 && !drained; c++) begin
      @(posedge clk);
      #1;
      if (!e_busy) drained = 1'b1;
    end
    chk("drain", 32'(drained), 32'd1);
    chk("drain_tp", 32'(e_tp), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
